// File: rtl/filter_iir_pkg.sv
// Shared constants and helpers for the multi-channel IIR filter family.
package filter_iir_pkg;

  // Guard bits on top of DW+CW so five full-scale products cannot overflow.
  localparam int ACC_GUARD = 3;

  // Rounding modes applied before the Q-format shift.
  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Overflow handling when narrowing back to DW bits.
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int chw_of(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

  // Full-precision accumulator width.
  function automatic int acc_w_of(input int dw, input int cw);
    return dw + cw + ACC_GUARD;
  endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Narrows a full-precision accumulator to a DW-bit sample: optional
// round-half-up, arithmetic shift by FRAC, then clamp or wrap with a flag.
module iir_round_sat
  import filter_iir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int FRAC  = 7,
  parameter int ROUND = ROUND_HALF_UP,
  parameter int SAT   = SAT_CLAMP,
  parameter int ACC_W = 18
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [DW-1:0]    y,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'((ROUND == ROUND_HALF_UP) ? (1 << (FRAC - 1)) : 0);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] wrapped;

  // Round, shift, then either clamp to the DW range or keep the low bits.
  always_comb begin
    rounded = acc + HALF;
    shifted = rounded >>> FRAC;
    wrapped = {{(ACC_W - DW){shifted[DW-1]}}, shifted[DW-1:0]};
    y       = shifted[DW-1:0];
    ovf     = 1'b0;
    if (SAT == SAT_CLAMP) begin
      if (shifted > MAXV) begin
        y   = MAXV[DW-1:0];
        ovf = 1'b1;
      end else if (shifted < MINV) begin
        y   = MINV[DW-1:0];
        ovf = 1'b1;
      end
    end else begin
      ovf = (wrapped != shifted);
    end
  end

endmodule

// File: rtl/filter_iir_mc.sv
// Time-multiplexed Direct Form I biquad with independent per-channel state.
// Stage 1 captures the sample and its coefficients; stage 2 reads the
// channel history, computes, registers the output and writes history back.
module filter_iir_mc
  import filter_iir_pkg::*;
#(
  parameter int  DW    = 8,
  parameter int  CW    = 8,
  parameter int  FRAC  = 7,
  parameter int  N_CH  = 4,
  parameter int  ROUND = 1,
  parameter int  SAT   = 1,
  localparam int CHW   = chw_of(N_CH),
  localparam int ACC_W = acc_w_of(DW, CW)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic signed [DW-1:0] DIN,
  input  logic                 VIN,
  input  logic [CHW-1:0]       CH_IN,
  input  logic signed [CW-1:0] a1,
  input  logic signed [CW-1:0] a2,
  input  logic signed [CW-1:0] b0,
  input  logic signed [CW-1:0] b1,
  input  logic signed [CW-1:0] b2,
  output logic signed [DW-1:0] DOUT,
  output logic                 VOUT,
  output logic [CHW-1:0]       CH_OUT,
  output logic                 OVF
);

  logic                    s1_valid;
  logic signed [DW-1:0]    s1_x;
  logic [CHW-1:0]          s1_ch;
  logic signed [CW-1:0]    s1_a1, s1_a2, s1_b0, s1_b1, s1_b2;

  logic signed [DW-1:0]    x1_mem [N_CH];
  logic signed [DW-1:0]    x2_mem [N_CH];
  logic signed [DW-1:0]    y1_mem [N_CH];
  logic signed [DW-1:0]    y2_mem [N_CH];

  logic                    accept;
  logic signed [CW-1:0]    tap_coef [5];
  logic signed [DW-1:0]    tap_data [5];
  logic signed [ACC_W-1:0] tap_prod [5];
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    y;
  logic                    ovf;

  // Out-of-range channels (non power-of-two N_CH) are silently dropped.
  assign accept = VIN && (32'(CH_IN) < 32'(N_CH));

  // Stage 1: capture sample, channel and the coefficients it will use.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_ch    <= '0;
      s1_a1    <= '0;
      s1_a2    <= '0;
      s1_b0    <= '0;
      s1_b1    <= '0;
      s1_b2    <= '0;
    end else if (CLR) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x  <= DIN;
        s1_ch <= CH_IN;
        s1_a1 <= a1;
        s1_a2 <= a2;
        s1_b0 <= b0;
        s1_b1 <= b1;
        s1_b2 <= b2;
      end
    end
  end

  // Feedback taps (3, 4) are subtracted below; the rest are added.
  assign tap_coef[0] = s1_b0;
  assign tap_coef[1] = s1_b1;
  assign tap_coef[2] = s1_b2;
  assign tap_coef[3] = s1_a1;
  assign tap_coef[4] = s1_a2;
  assign tap_data[0] = s1_x;
  assign tap_data[1] = x1_mem[s1_ch];
  assign tap_data[2] = x2_mem[s1_ch];
  assign tap_data[3] = y1_mem[s1_ch];
  assign tap_data[4] = y2_mem[s1_ch];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_tap
      assign tap_prod[gi] = ACC_W'(tap_coef[gi]) * ACC_W'(tap_data[gi]);
    end
  endgenerate

  assign acc = tap_prod[0] + tap_prod[1] + tap_prod[2] - tap_prod[3] - tap_prod[4];

  iir_round_sat #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ROUND (ROUND),
    .SAT   (SAT),
    .ACC_W (ACC_W)
  ) u_round_sat (
    .acc (acc),
    .y   (y),
    .ovf (ovf)
  );

  // Stage 2: register the result and shift the channel's history; CLR wins.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      DOUT   <= '0;
      VOUT   <= 1'b0;
      CH_OUT <= '0;
      OVF    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
    end else if (CLR) begin
      VOUT <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
    end else begin
      VOUT <= s1_valid;
      if (s1_valid) begin
        DOUT          <= y;
        CH_OUT        <= s1_ch;
        OVF           <= ovf;
        x2_mem[s1_ch] <= x1_mem[s1_ch];
        x1_mem[s1_ch] <= s1_x;
        y2_mem[s1_ch] <= y1_mem[s1_ch];
        y1_mem[s1_ch] <= y;
      end
    end
  end

endmodule

// File: tb/tb_filter_iir_mc.sv
// Bench for filter_iir_mc: a per-channel integer model predicts every output
// two edges after acceptance; directed sequences pin the model to known values.
module tb_filter_iir_mc;

  localparam int EXP_N = 4096;

  logic              clk = 1'b0;
  logic              RST;
  logic              CLR;
  logic signed [7:0] DIN;
  logic              VIN;
  logic [1:0]        CH_IN;
  logic signed [7:0] a1, a2, b0, b1, b2;
  logic signed [7:0] DOUT;
  logic              VOUT;
  logic [1:0]        CH_OUT;
  logic              OVF;

  logic              VIN2;
  logic [1:0]        CH_IN2;
  logic signed [7:0] DOUT2;
  logic              VOUT2;
  logic [1:0]        CH_OUT2;
  logic              OVF2;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  int exp_v [EXP_N];
  int exp_d [EXP_N];
  int exp_c [EXP_N];
  int exp_o [EXP_N];

  int mx1 [4], mx2 [4], my1 [4], my2 [4];
  int c_a1, c_a2, c_b0, c_b1, c_b2;
  int last_y, last_o;

  always #5 clk = ~clk;

  filter_iir_mc #(
    .DW(8), .CW(8), .FRAC(7), .N_CH(4), .ROUND(1), .SAT(1)
  ) dut (
    .clk(clk), .RST(RST), .CLR(CLR), .DIN(DIN), .VIN(VIN), .CH_IN(CH_IN),
    .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
    .DOUT(DOUT), .VOUT(VOUT), .CH_OUT(CH_OUT), .OVF(OVF)
  );

  filter_iir_mc #(
    .DW(8), .CW(8), .FRAC(7), .N_CH(3), .ROUND(1), .SAT(1)
  ) dut3 (
    .clk(clk), .RST(RST), .CLR(CLR), .DIN(DIN), .VIN(VIN2), .CH_IN(CH_IN2),
    .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
    .DOUT(DOUT2), .VOUT(VOUT2), .CH_OUT(CH_OUT2), .OVF(OVF2)
  );

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endfunction

  // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, Q1.7, round half up, clamp.
  task automatic model_sample(input int ch, input int x, output int y, output int o);
    int acc;
    int q;
    acc = int'(b0) * x + int'(b1) * mx1[ch] + int'(b2) * mx2[ch]
        - int'(a1) * my1[ch] - int'(a2) * my2[ch];
    q = (acc + 64) >>> 7;
    o = 0;
    y = q;
    if (q > 127) begin y = 127; o = 1; end
    if (q < -128) begin y = -128; o = 1; end
    mx2[ch] = mx1[ch];
    mx1[ch] = x;
    my2[ch] = my1[ch];
    my1[ch] = y;
  endtask

  // One clock of stimulus on the 4-channel DUT, with the model kept in step.
  task automatic drive(input bit v, input int ch, input int x, input bit clr);
    int e;
    int y;
    int o;
    @(negedge clk);
    a1 = 8'(c_a1); a2 = 8'(c_a2); b0 = 8'(c_b0); b1 = 8'(c_b1); b2 = 8'(c_b2);
    VIN = v; CH_IN = 2'(ch); DIN = 8'(x); CLR = clr;
    e = edge_cnt + 1;
    if (clr) begin
      exp_v[e] = 0;
      model_clear();
    end else if (v) begin
      model_sample(ch, x, y, o);
      exp_v[e+1] = 1;
      exp_d[e+1] = y;
      exp_c[e+1] = ch;
      exp_o[e+1] = o;
      last_y = y;
      last_o = o;
    end
  endtask

  task automatic set_coef(input int na1, input int na2, input int nb0,
                          input int nb1, input int nb2);
    c_a1 = na1; c_a2 = na2; c_b0 = nb0; c_b1 = nb1; c_b2 = nb2;
  endtask

  // Cycle-by-cycle comparison of the 4-channel DUT against the model.
  always @(posedge clk) begin
    #1;
    edge_cnt = edge_cnt + 1;
    chk("vout", VOUT, exp_v[edge_cnt]);
    if (exp_v[edge_cnt] != 0) begin
      chk("dout", DOUT, exp_d[edge_cnt]);
      chk("ch_out", CH_OUT, exp_c[edge_cnt]);
      chk("ovf", OVF, exp_o[edge_cnt]);
      $display("out edge=%0d ch=%0d dout=%0d ovf=%0d", edge_cnt, CH_OUT, DOUT, OVF);
    end
  end

  initial begin
    int rec_exp [7];
    int il_exp [6];
    rec_exp = '{50, 25, 13, 7, 4, 2, 1};
    il_exp  = '{50, -50, 25, -25, 13, -12};

    RST = 1'b0; CLR = 1'b0; VIN = 1'b0; CH_IN = '0; DIN = '0;
    VIN2 = 1'b0; CH_IN2 = '0;
    set_coef(0, 0, 0, 0, 0);
    a1 = '0; a2 = '0; b0 = '0; b1 = '0; b2 = '0;
    model_clear();
    #1 RST = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_dout", DOUT, 0);
    chk("reset_vout", VOUT, 0);
    chk("reset_ch_out", CH_OUT, 0);
    chk("reset_ovf", OVF, 0);
    @(negedge clk);
    RST = 1'b0;

    // Gain of 0.5 on channel 0
    set_coef(0, 0, 64, 0, 0);
    drive(1, 0, 100, 0);  chk("gain_pos", last_y, 50);
    drive(1, 0, -100, 0); chk("gain_neg", last_y, -50);
    drive(0, 0, 0, 0);

    // First-order recursion on channel 1
    set_coef(-64, 0, 64, 0, 0);
    for (int k = 0; k < 7; k++) begin
      drive(1, 1, (k == 0) ? 100 : 0, 0);
      chk($sformatf("recursion_%0d", k), last_y, rec_exp[k]);
    end
    drive(0, 0, 0, 0);

    // Saturation on channel 2
    set_coef(0, 0, 127, 127, 0);
    drive(1, 2, 127, 0); chk("sat_first", last_y, 126); chk("sat_first_ovf", last_o, 0);
    drive(1, 2, 127, 0); chk("sat_second", last_y, 127); chk("sat_second_ovf", last_o, 1);
    drive(0, 0, 0, 0);

    // Interleaved channels 0 and 3 from a clean state
    set_coef(-64, 0, 64, 0, 0);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      drive(1, (k % 2 == 0) ? 0 : 3, (k < 2) ? ((k == 0) ? 100 : -100) : 0, 0);
      chk($sformatf("interleave_%0d", k), last_y, il_exp[k]);
    end
    drive(0, 0, 0, 0);

    // CLR with a simultaneous sample, then a fresh impulse
    drive(1, 1, 100, 0);
    drive(0, 1, 0, 0);
    drive(1, 1, 77, 1);
    drive(1, 1, 100, 0); chk("clr_then_impulse", last_y, 50);
    drive(0, 0, 0, 0);

    // Asynchronous reset mid-stream
    drive(1, 3, 100, 0);
    drive(1, 3, 100, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_dout", DOUT, 50);
    VIN = 1'b0;
    RST = 1'b1;
    for (int k = edge_cnt + 1; k <= edge_cnt + 3; k++) exp_v[k] = 0;
    model_clear();
    #1;
    chk("rst_async_dout", DOUT, 0);
    chk("rst_async_vout", VOUT, 0);
    chk("rst_async_ch_out", CH_OUT, 0);
    chk("rst_async_ovf", OVF, 0);
    @(negedge clk);
    RST = 1'b0;
    drive(1, 3, 100, 0); chk("rst_then_impulse", last_y, 50);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Invalid channel on the 3-channel instance
    @(negedge clk);
    VIN2 = 1'b1; CH_IN2 = 2'd3; DIN = 8'sd100;
    @(negedge clk);
    VIN2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      chk("inv_no_vout", VOUT2, 0);
    end
    @(negedge clk);
    VIN2 = 1'b1; CH_IN2 = 2'd0; DIN = 8'sd100;
    @(negedge clk);
    DIN = 8'sd0;
    @(posedge clk);
    #2;
    chk("inv_ch0_vout", VOUT2, 1);
    chk("inv_ch0_dout", DOUT2, 50);
    chk("inv_ch0_ch", CH_OUT2, 0);
    @(negedge clk);
    VIN2 = 1'b0;
    @(posedge clk);
    #2;
    chk("inv_ch0_vout2", VOUT2, 1);
    chk("inv_ch0_dout2", DOUT2, 25);
    @(posedge clk);
    #2;
    chk("inv_idle_vout", VOUT2, 0);

    // Randomised traffic: coefficient sets, channels, gaps and clears
    for (int i = 0; i < 1500; i++) begin
      if (i % 25 == 0) begin
        if ($urandom_range(1, 0) == 1)
          set_coef(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                   int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                   int'($urandom_range(255)) - 128);
        else
          set_coef(int'($urandom_range(64)) - 32, int'($urandom_range(32)) - 16,
                   int'($urandom_range(128)) - 64, int'($urandom_range(128)) - 64,
                   int'($urandom_range(128)) - 64);
      end
      drive($urandom_range(99) < 75, int'($urandom_range(3)),
            int'($urandom_range(255)) - 128, $urandom_range(99) < 2);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #3;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
